// File: rtl/ascon_serial_collector.sv
// ----------------------------------------------------------------------------
// ascon_serial_collector
//
// Purpose:
//   Deserializer placed directly after the bit-serial Ascon core. It watches
//   the core's ready flag for a rising edge, waits GAP idle cycles, then
//   samples one data bit and one tag bit per clock for MAX cycles. The
//   assembled words are then offered on a valid/ready interface together
//   with a registered compare of the captured tag against exp_tag.
//   The same block serves encryption or decryption; which core outputs
//   feed it is decided purely by top-level wiring.
//
// Parameters:
//   Y   - data word width in bits (Y <= MAX)
//   MAX - serial window length in cycles (MAX >= Y, MAX >= 128)
//   GAP - idle cycles between the ready edge and the first sample (0 legal)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   readyxSI   in   core ready flag (encryption_ready / decryption_ready)
//   dataxSI    in   serial data bit (ciphertext or plaintext)
//   tagxSI     in   serial tag bit
//   exp_tag    in   expected tag, sampled on the final capture edge
//   out_ready  in   downstream accepts the result
//   data_out   out  assembled data word (Y bits)
//   tag_out    out  assembled 128-bit tag
//   out_valid  out  result available
//   tag_match  out  tag_out == exp_tag, meaningful while out_valid is high
//   busy       out  capture in progress (GAP or SHIFT)
//   overrun    out  sticky: a ready edge arrived while not idle
// ----------------------------------------------------------------------------
module ascon_serial_collector #(
  parameter int Y   = 256,
  parameter int MAX = 256,
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           readyxSI,
  input  logic           dataxSI,
  input  logic           tagxSI,
  input  logic [127:0]   exp_tag,
  input  logic           out_ready,
  output logic [Y-1:0]   data_out,
  output logic [127:0]   tag_out,
  output logic           out_valid,
  output logic           tag_match,
  output logic           busy,
  output logic           overrun
);

  localparam int CNT_TOP = (MAX > GAP) ? MAX : GAP;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] LAST_SHIFT = CW'(MAX - 1);
  // Only reachable when GAP > 0; the GAP = 0 value is a don't-care.
  localparam logic [CW-1:0] LAST_GAP   = (GAP > 0) ? CW'(GAP - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_rdy_q;
  logic [Y-1:0]     r_data;
  logic [127:0]     r_tag;
  logic             r_out_valid;
  logic             r_tag_match;
  logic             r_busy;
  logic             r_overrun;

  logic             w_trigger;
  logic [Y-1:0]     w_data_next;
  logic [127:0]     w_tag_next;

  // Rising edge of the ready flag. r_rdy_q resets to 0, so a flag that is
  // already high right after reset is seen as an edge.
  assign w_trigger = readyxSI & ~r_rdy_q;

  // Capture vectors with the current bit index replaced by the serial inputs;
  // indices beyond the word widths never match and are discarded.
  always_comb begin
    w_data_next = r_data;
    w_tag_next  = r_tag;
    for (int k = 0; k < Y; k++) begin
      if (r_cnt == CW'(k)) begin
        w_data_next[k] = dataxSI;
      end else begin
        w_data_next[k] = r_data[k];
      end
    end
    for (int k = 0; k < 128; k++) begin
      if (r_cnt == CW'(k)) begin
        w_tag_next[k] = tagxSI;
      end else begin
        w_tag_next[k] = r_tag[k];
      end
    end
  end

  // Control FSM, bit counter, capture registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_rdy_q     <= 1'b0;
      r_data      <= {Y{1'b0}};
      r_tag       <= 128'd0;
      r_out_valid <= 1'b0;
      r_tag_match <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rdy_q <= readyxSI;

      // Edges outside IDLE (including the handshake edge) are dropped but
      // remembered in the sticky overrun flag.
      if (w_trigger && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= (GAP > 0) ? S_GAP : S_SHIFT;
          end
        end

        S_GAP: begin
          if (r_cnt == LAST_GAP) begin
            r_cnt   <= {CW{1'b0}};
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_SHIFT: begin
          r_data <= w_data_next;
          r_tag  <= w_tag_next;
          if (r_cnt == LAST_SHIFT) begin
            r_cnt       <= {CW{1'b0}};
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            // Compare uses this edge's tag bit as well.
            r_tag_match <= (w_tag_next == exp_tag);
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_HOLD: begin
          // data/tag keep their values after the handshake until the next
          // capture overwrites them bit by bit.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= {CW{1'b0}};
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign tag_out   = r_tag;
  assign out_valid = r_out_valid;
  assign tag_match = r_tag_match;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ascon_serial_collector.sv
// ----------------------------------------------------------------------------
// Testbench for ascon_serial_collector.
// Instance A: Y=256, MAX=256, GAP=2.  Instance B: Y=128, MAX=256, GAP=0.
// Inputs are driven just after the falling edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_ascon_serial_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy_a, rdy_b;
  logic         din, tin;
  logic         ordy_a, ordy_b;
  logic [127:0] exp_tag;

  logic [255:0] data_a;
  logic [127:0] tag_a;
  logic         ov_a, tm_a, busy_a, ovr_a;
  logic [127:0] data_b;
  logic [127:0] tag_b;
  logic         ov_b, tm_b, busy_b, ovr_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ascon_serial_collector #(.Y(256), .MAX(256), .GAP(2)) u_dut_a (
    .clk(clk), .rst(rst), .readyxSI(rdy_a), .dataxSI(din), .tagxSI(tin),
    .exp_tag(exp_tag), .out_ready(ordy_a),
    .data_out(data_a), .tag_out(tag_a), .out_valid(ov_a),
    .tag_match(tm_a), .busy(busy_a), .overrun(ovr_a)
  );

  ascon_serial_collector #(.Y(128), .MAX(256), .GAP(0)) u_dut_b (
    .clk(clk), .rst(rst), .readyxSI(rdy_b), .dataxSI(din), .tagxSI(tin),
    .exp_tag(exp_tag), .out_ready(ordy_b),
    .data_out(data_b), .tag_out(tag_b), .out_valid(ov_b),
    .tag_match(tm_b), .busy(busy_b), .overrun(ovr_b)
  );

  typedef struct {
    logic [255:0] data;
    logic [127:0] tag;
    logic [127:0] etag;
    logic         match;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic set_rdy(input bit use_b, input logic v);
    if (use_b) rdy_b = v;
    else       rdy_a = v;
  endtask

  task automatic get_out(input bit use_b, output logic [255:0] od, output logic [127:0] ot,
                         output logic ov, output logic om, output logic ob, output logic oo);
    if (use_b) begin
      od = {128'd0, data_b}; ot = tag_b; ov = ov_b; om = tm_b; ob = busy_b; oo = ovr_b;
    end else begin
      od = data_a; ot = tag_a; ov = ov_a; om = tm_a; ob = busy_a; oo = ovr_a;
    end
  endtask

  // Called and returns just after a falling edge. Raises ready (next rising
  // edge is E0), streams bits so that bit i is sampled at E0+gap+1+i, checks
  // the result, optionally holds it for hold_cyc cycles, then handshakes.
  // rst_at >= 0 aborts with a one-edge reset at that sample index instead.
  task automatic capture(input bit use_b, input logic [255:0] d, input logic [127:0] t,
                         input logic [127:0] et, input logic exp_m, input int glitch_at,
                         input int rst_at, input logic exp_ovr, input int hold_cyc);
    int gap;
    int i;
    logic [255:0] od, exp_d;
    logic [127:0] ot;
    logic ov, om, ob, oo;
    gap     = use_b ? 0 : 2;
    exp_d   = use_b ? {128'd0, d[127:0]} : d;
    exp_tag = et;
    set_rdy(use_b, 1'b1);
    @(posedge clk);
    for (int e = 1; e <= gap + 256; e++) begin
      @(negedge clk);
      i = e - gap - 1;
      if (i >= 0) begin
        din = d[i];
        tin = (i < 128) ? t[i] : 1'b1;
        if (i == glitch_at - 1) set_rdy(use_b, 1'b0);
        if (i == glitch_at)     set_rdy(use_b, 1'b1);
        if (i == rst_at) begin
          rst = 1'b1;
          set_rdy(use_b, 1'b0);
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      if (e == gap + 256) begin
        get_out(use_b, od, ot, ov, om, ob, oo);
        chk1("valid_before_last_edge", ov, 1'b0);
        chk1("busy_during_capture", ob, 1'b1);
      end
      @(posedge clk);
    end
    @(negedge clk);
    set_rdy(use_b, 1'b0);
    get_out(use_b, od, ot, ov, om, ob, oo);
    chk1("valid_after_window", ov, 1'b1);
    chk("data_out", od, exp_d);
    chk("tag_out", {128'd0, ot}, {128'd0, t});
    chk1("tag_match", om, exp_m);
    chk1("busy_at_valid", ob, 1'b0);
    chk1("overrun", oo, exp_ovr);
    if (hold_cyc > 0) begin
      repeat (hold_cyc) @(negedge clk);
      get_out(use_b, od, ot, ov, om, ob, oo);
      chk1("hold_valid_stable", ov, 1'b1);
      chk("hold_data_stable", od, exp_d);
      chk("hold_tag_stable", {128'd0, ot}, {128'd0, t});
      chk1("hold_match_stable", om, exp_m);
    end
    if (use_b) ordy_b = 1'b1; else ordy_a = 1'b1;
    @(negedge clk);
    if (use_b) ordy_b = 1'b0; else ordy_a = 1'b0;
    get_out(use_b, od, ot, ov, om, ob, oo);
    chk1("valid_after_handshake", ov, 1'b0);
    chk1("busy_after_handshake", ob, 1'b0);
    chk("data_kept_after_handshake", od, exp_d);
  endtask

  initial begin
    int bad;
    logic [127:0] t_spec;
    t_spec = 128'h3f3607dbce3503ba84f5843d623de056;

    vecs[0] = '{data: {4{64'h0123456789abcdef}}, tag: t_spec, etag: t_spec, match: 1'b1};
    vecs[1] = '{data: {4{64'h0123456789abcdef}}, tag: t_spec,
                etag: t_spec ^ 128'h1, match: 1'b0};
    vecs[2] = '{data: 256'd0, tag: {128{1'b1}}, etag: {128{1'b1}}, match: 1'b1};
    vecs[3] = '{data: {16{16'ha55a}}, tag: {4{32'h80000001}},
                etag: {4{32'h80000001}} ^ {1'b1, 127'd0}, match: 1'b0};

    rst = 1'b1; rdy_a = 1'b0; rdy_b = 1'b1;
    din = 1'b0; tin = 1'b0; ordy_a = 1'b0; ordy_b = 1'b0; exp_tag = 128'd0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_data", data_a, 256'd0);
    chk("rst_tag", {128'd0, tag_a}, 256'd0);
    chk1("rst_valid", ov_a, 1'b0);
    chk1("rst_match", tm_a, 1'b0);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_overrun", ovr_a, 1'b0);
    chk1("rst_busy_b", busy_b, 1'b0);

    // B: ready already high when reset releases counts as a trigger;
    // GAP=0, Y=128, data constantly 1.
    rst = 1'b0;
    capture(1'b1, {256{1'b1}}, 128'hfedcba9876543210_0f1e2d3c4b5a6978,
            128'hfedcba9876543210_0f1e2d3c4b5a6978, 1'b1, -1, -1, 1'b0, 0);

    // A: table of captures, each held 10 cycles before the handshake.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      capture(1'b0, vecs[v].data, vecs[v].tag, vecs[v].etag, vecs[v].match,
              -1, -1, 1'b0, 10);
    end

    // Re-trigger mid-SHIFT at i=100: capture unchanged, overrun sticky.
    @(negedge clk);
    capture(1'b0, vecs[0].data, vecs[0].tag, vecs[0].etag, 1'b1, 100, -1, 1'b1, 0);
    repeat (5) @(negedge clk);
    chk1("overrun_sticky", ovr_a, 1'b1);

    // Reset at i=50 of SHIFT.
    capture(1'b0, vecs[3].data, vecs[3].tag, vecs[3].etag, 1'b0, -1, 50, 1'b0, 0);
    chk("midrst_data", data_a, 256'd0);
    chk("midrst_tag", {128'd0, tag_a}, 256'd0);
    chk1("midrst_valid", ov_a, 1'b0);
    chk1("midrst_match", tm_a, 1'b0);
    chk1("midrst_busy", busy_a, 1'b0);
    chk1("midrst_overrun", ovr_a, 1'b0);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ov_a || busy_a) bad++;
    end
    chk1("no_valid_without_trigger", (bad != 0), 1'b0);

    // Fresh capture after reset.
    capture(1'b0, vecs[2].data, vecs[2].tag, vecs[2].etag, 1'b1, -1, -1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_serial_collector.md
# ascon_serial_collector

Output-side deserializer that sits directly downstream of the bit-serial `Ascon` core. It detects the rising edge of the core's ready flag and waits a fixed gap. It then samples the serial ciphertext/plaintext bit and tag bit once per clock for the core's output window, and presents the assembled words on a parallel valid/ready interface. The same instance serves encryption (`cipher_textxSO`/`tagxSO`) or decryption (`plain_textxS0`/`dec_tagxSO`), selected by top-level wiring. It also flags a tag match against an expected tag.

## Interface
- `Y`, 256: data length in bits; width of `data_out`.
- `MAX`, 256: serial window length in cycles, equal to max(k, l, y) of the core; must satisfy MAX ≥ Y and MAX ≥ 128.
- `GAP`, 2: idle cycles between the detected ready edge and the first sample; 0 is legal.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `readyxSI` in 1: core ready flag (`encryption_readyxSO` or `decryption_readyxSO`).
- `dataxSI` in 1: serial data bit from the core.
- `tagxSI` in 1: serial tag bit from the core.
- `exp_tag` in 128: expected tag; sampled on the final capture edge.
- `out_ready` in 1: downstream accepts the result.
- `data_out` out Y: assembled data word.
- `tag_out` out 128: assembled tag.
- `out_valid` out 1: result available.
- `tag_match` out 1: `tag_out` equals `exp_tag`; meaningful only while `out_valid` is high.
- `busy` out 1: high in GAP and SHIFT.
- `overrun` out 1: sticky error flag.

## Operation
- FSM states: IDLE, GAP, SHIFT, HOLD. Counter `cnt` is clog2(max(MAX, GAP) + 1) bits wide.
- Edge detect: register `rdy_q` follows `readyxSI` every cycle and resets to 0. A trigger is `readyxSI & ~rdy_q`. If `readyxSI` is already high on the first cycle after reset, that counts as a trigger.
- IDLE:
  - On trigger with GAP > 0: go to GAP, `cnt` = 0.
  - On trigger with GAP = 0: go straight to SHIFT, `cnt` = 0.
- GAP: `cnt` increments each cycle. On the edge where `cnt` == GAP−1, go to SHIFT and set `cnt` = 0.
- SHIFT, each edge at index i = `cnt`:
  - If i < Y: `data_out[i]` ← `dataxSI`.
  - If i < 128: `tag_out[i]` ← `tagxSI`.
  - Bits at i ≥ Y or i ≥ 128 are discarded.
  - `cnt` increments.
  - On the edge where i == MAX−1: go to HOLD, set `out_valid` = 1, and register `tag_match` = (final tag value including this edge's bit == `exp_tag`).
- HOLD:
  - `data_out`, `tag_out`, `tag_match` and `out_valid` hold stable.
  - On an edge with `out_valid & out_ready`: go to IDLE and clear `out_valid`. `data_out`/`tag_out` keep their values until the next capture overwrites them bit by bit.
- Triggers are recognised only in IDLE. A trigger in GAP, SHIFT or HOLD, including the handshake edge itself, is ignored and sets `overrun` = 1. `overrun` clears only on `rst`.
- `rst` asserted in any state, including mid-SHIFT:
  - next state IDLE; `cnt`, `rdy_q` cleared;
  - all outputs 0; partial capture discarded.

## Timing
- Reset values: `data_out` = 0, `tag_out` = 0, `out_valid` = 0, `tag_match` = 0, `busy` = 0, `overrun` = 0.
- Let E0 be the trigger edge.
  - Samples are taken at edges E0+GAP+1 through E0+GAP+MAX.
  - `out_valid` is high from the cycle after E0+GAP+MAX.
  - Trigger-to-valid latency: GAP+MAX cycles.
- `busy` is high from the cycle after E0 until the cycle `out_valid` rises.
- `out_ready` is ignored outside HOLD. If `out_ready` is held high, HOLD lasts exactly one cycle.
- Earliest next capture: trigger accepted on the edge after the handshake edge.

## Test plan
- Y=256, MAX=256, GAP=2, `exp_tag` = tag. Drive `readyxSI` 0→1 at edge E0. From E0+3, drive serial bits so that `data_out` = 0x0123456789abcdef repeated 4× (bit i at edge E0+3+i) and `tag_out` = 0x3f3607dbce3503ba84f5843d623de056. Required:
  - `out_valid` rises after E0+258 with those exact values;
  - `tag_match` = 1, `busy` low, `overrun` = 0.
- Same capture with `exp_tag` differing in bit 0 → `tag_match` = 0.
- GAP=0, MAX=256, Y=128, `dataxSI` = 1 constantly → `data_out` = all ones (128 bits); `out_valid` rises after E0+256; bits at i ≥ 128 discarded.
- Hold `out_ready` = 0 for 10 cycles in HOLD → outputs stable; then pulse `out_ready` → `out_valid` = 0 next cycle and state IDLE. A new 0→1 on `readyxSI` starts a second capture with correct data.
- Pulse `readyxSI` low→high again mid-SHIFT (i=100) → capture finishes unchanged at the original timing; `overrun` = 1 and stays 1 until `rst`.
- Assert `rst` for one edge at i=50 of SHIFT → next cycle all outputs 0 and state IDLE. No `out_valid` appears without a fresh trigger.
